wys_1780_3_seq_ctrl: RTL and testbench

//   Sequencer for the 6-lamp sweep decoder: generates the 3-bit step index Q (0..6) that the decoder

---
 rtl/wys_seq_pkg.sv | 20 ++
 rtl/wys_seq_prescaler.sv | 34 +++
 rtl/wys_1780_3_seq_ctrl.sv | 160 ++++++++++++++++
 tb/tb_wys_1780_3_seq_ctrl.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/wys_seq_pkg.sv
// ============================================================================
// wys_seq_pkg : shared state encoding and step constants for the sweep sequencer
// Revision    : 1.0
// ============================================================================
`default_nettype none

package wys_seq_pkg;

    localparam int Q_W = 3;
    localparam logic [Q_W-1:0] LAST_STEP = 3'd6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_UP   = 2'd1,
        ST_DOWN = 2'd2
    } seq_state_t;

endpackage

`default_nettype wire

// File: rtl/wys_seq_prescaler.sv
// ============================================================================
// wys_seq_prescaler : divides clk by DIV, one-cycle tick at count DIV-1
// Revision          : 1.0
// ============================================================================
`default_nettype none

module wys_seq_prescaler #(
    parameter int DIV   = 12_500_000,
    parameter int DIV_W = 24
) (
    input  logic clk,
    input  logic rst,
    input  logic en_i,
    output logic tick_o
);

    logic [DIV_W-1:0] cnt_q;

    assign tick_o = en_i && (cnt_q == DIV_W'(DIV - 1));

    // Disabling the prescaler clears it so every sweep starts a full dwell.
    always_ff @(posedge clk) begin
        if (rst || !en_i) begin
            cnt_q <= '0;
        end else if (tick_o) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + DIV_W'(1);
        end
    end

endmodule

`default_nettype wire

// File: rtl/wys_1780_3_seq_ctrl.sv
// ============================================================================
// wys_1780_3_seq_ctrl : step-index sequencer for the 6-lamp sweep decoder
//                       (single, loop, stop; ping-pong with WYS_SEQ_PINGPONG_EN)
// Revision            : 1.0
// ============================================================================
`default_nettype none

module wys_1780_3_seq_ctrl
    import wys_seq_pkg::*;
#(
    parameter int             DIV   = 12_500_000,
    parameter int             DIV_W = 24,
    parameter logic [Q_W-1:0] LAST  = LAST_STEP
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start_i,
    input  logic           stop_i,
    input  logic           loop_i,
    input  logic           pp_i,
    output logic [Q_W-1:0] q_o,
    output logic           busy_o,
    output logic           step_o,
    output logic           done_o
);

    seq_state_t     state_q, state_d;
    logic [Q_W-1:0] q_q, q_d;
    logic           busy_q, busy_d;
    logic           step_q, step_d;
    logic           done_q, done_d;
    logic           loop_q, loop_d;
    logic           w_tick;
    logic           w_pre_en;

`ifdef WYS_SEQ_PINGPONG_EN
    logic           pp_q, pp_d;
`else
    logic           w_unused_pp;
    assign w_unused_pp = pp_i;
`endif

    // Clearing on stop lets the prescaler restart from zero on the same edge.
    assign w_pre_en = (state_q != ST_IDLE) && !stop_i;

    wys_seq_prescaler #(
        .DIV   (DIV),
        .DIV_W (DIV_W)
    ) u_prescaler (
        .clk    (clk),
        .rst    (rst),
        .en_i   (w_pre_en),
        .tick_o (w_tick)
    );

    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        step_d  = 1'b0;
        done_d  = 1'b0;
        loop_d  = loop_q;
`ifdef WYS_SEQ_PINGPONG_EN
        pp_d    = pp_q;
`endif
        case (state_q)
            ST_IDLE: begin
                q_d = '0;
                if (start_i && !stop_i) begin
                    state_d = ST_UP;
                    loop_d  = loop_i;
`ifdef WYS_SEQ_PINGPONG_EN
                    pp_d    = pp_i;
`endif
                end
            end
            ST_UP: begin
                if (stop_i) begin
                    state_d = ST_IDLE;
                    q_d     = '0;
                end else if (w_tick) begin
                    if (q_q < LAST) begin
                        q_d    = q_q + Q_W'(1);
                        step_d = 1'b1;
`ifdef WYS_SEQ_PINGPONG_EN
                    end else if (pp_q) begin
                        state_d = ST_DOWN;
                        q_d     = LAST - Q_W'(1);
                        step_d  = 1'b1;
`endif
                    end else if (loop_q) begin
                        q_d    = '0;
                        step_d = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                        q_d     = '0;
                        done_d  = 1'b1;
                    end
                end
            end
`ifdef WYS_SEQ_PINGPONG_EN
            ST_DOWN: begin
                if (stop_i) begin
                    state_d = ST_IDLE;
                    q_d     = '0;
                end else if (w_tick) begin
                    if (q_q != '0) begin
                        q_d    = q_q - Q_W'(1);
                        step_d = 1'b1;
                    end else if (loop_q) begin
                        state_d = ST_UP;
                        q_d     = Q_W'(1);
                        step_d  = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                        q_d     = '0;
                        done_d  = 1'b1;
                    end
                end
            end
`endif
            default: begin
                state_d = ST_IDLE;
                q_d     = '0;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            q_q     <= '0;
            busy_q  <= 1'b0;
            step_q  <= 1'b0;
            done_q  <= 1'b0;
            loop_q  <= 1'b0;
`ifdef WYS_SEQ_PINGPONG_EN
            pp_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            busy_q  <= busy_d;
            step_q  <= step_d;
            done_q  <= done_d;
            loop_q  <= loop_d;
`ifdef WYS_SEQ_PINGPONG_EN
            pp_q    <= pp_d;
`endif
        end
    end

    assign q_o    = q_q;
    assign busy_o = busy_q;
    assign step_o = step_q;
    assign done_o = done_q;

endmodule

`default_nettype wire

// File: tb/tb_wys_1780_3_seq_ctrl.sv
// ============================================================================
// tb_wys_1780_3_seq_ctrl : self-checking bench for the sweep sequencer (DIV=4)
// Revision               : 1.0
// ============================================================================
`default_nettype none

module tb_wys_1780_3_seq_ctrl;

    localparam int DIV = 4;

    logic       clk;
    logic       rst;
    logic       start_i, stop_i, loop_i, pp_i;
    logic [2:0] q_o;
    logic       busy_o, step_o, done_o;

    int total = 0;
    int bad   = 0;

    wys_1780_3_seq_ctrl #(
        .DIV   (DIV),
        .DIV_W (24)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start_i (start_i),
        .stop_i  (stop_i),
        .loop_i  (loop_i),
        .pp_i    (pp_i),
        .q_o     (q_o),
        .busy_o  (busy_o),
        .step_o  (step_o),
        .done_o  (done_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int eq, input int eb, input int es, input int ed);
        chk({tag, ".q"},    {5'd0, q_o},    8'(eq));
        chk({tag, ".busy"}, {7'd0, busy_o}, 8'(eb));
        chk({tag, ".step"}, {7'd0, step_o}, 8'(es));
        chk({tag, ".done"}, {7'd0, done_o}, 8'(ed));
    endtask

    // Value shown during the i-th dwell of an up/down sweep.
    function automatic int tri_val(input int i);
        return (i <= 6) ? i : 12 - i;
    endfunction

    // Expected outputs k cycles after the start edge.
    task automatic model(input int k, input bit lp, input bit p,
                         output int eq, output int eb, output int es, output int ed);
        int idx;
        int len;
        bit first;
        idx   = k / DIV;
        first = (k % DIV == 0) && (k > 0);
        if (lp) begin
            if (p) eq = (idx == 0) ? 0 : tri_val(((idx - 1) % 12) + 1);
            else   eq = idx % 7;
            eb = 1; es = int'(first); ed = 0;
        end else begin
            len = p ? 13 : 7;
            if (idx < len) begin
                eq = tri_val(idx); eb = 1; es = int'(first); ed = 0;
            end else begin
                eq = 0; eb = 0; es = 0; ed = int'(k == len * DIV);
            end
        end
    endtask

    // One sweep: start with (lp,p), observe ncyc cycles, optionally abort at edge abort_k.
    task automatic run(input string tag, input bit lp, input bit p, input int ncyc,
                       input int abort_k, input bit abort_rst, input bit noise);
        int eq, eb, es, ed;
        bit pe;
`ifdef WYS_SEQ_PINGPONG_EN
        pe = p;
`else
        pe = 1'b0;
`endif
        @(negedge clk);
        start_i = 1'b1; loop_i = lp; pp_i = p; stop_i = 1'b0;
        for (int k = 0; k < ncyc; k++) begin
            @(negedge clk);
            if (abort_k >= 0 && k >= abort_k) begin
                eq = 0; eb = 0; es = 0; ed = 0;
            end else begin
                model(k, lp, pe, eq, eb, es, ed);
            end
            chk_all($sformatf("%s.k%0d", tag, k), eq, eb, es, ed);
            start_i = (noise && eb == 1) ? 1'($urandom % 2) : 1'b0;
            if (noise) begin
                loop_i = 1'($urandom % 2);
                pp_i   = 1'($urandom % 2);
            end
            if (k + 1 == abort_k) begin
                if (abort_rst) rst = 1'b1;
                else           stop_i = 1'b1;
            end else begin
                rst = 1'b0; stop_i = 1'b0;
            end
        end
        start_i = 1'b0; stop_i = 1'b0; rst = 1'b0;
    endtask

    initial begin
        bit lp, p, ar;
        int ab;
        rst = 1'b1; start_i = 1'b0; stop_i = 1'b0; loop_i = 1'b0; pp_i = 1'b0;
        @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk_all($sformatf("reset%0d", i), 0, 0, 0, 0);
        end
        rst = 1'b0;
        @(negedge clk);
        chk_all("post_reset", 0, 0, 0, 0);

        stop_i = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk_all("stop_idle", 0, 0, 0, 0);
        end
        start_i = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk_all("start_stop_idle", 0, 0, 0, 0);
        end
        start_i = 1'b0; stop_i = 1'b0;

        run("single",      1'b0, 1'b0, 32, -1, 1'b0, 1'b0);
        run("single_nz",   1'b0, 1'b0, 32, -1, 1'b0, 1'b1);
        run("loop_stop",   1'b1, 1'b0, 46, 41, 1'b0, 1'b0);
        run("pp_single",   1'b0, 1'b1, 56, -1, 1'b0, 1'b0);
        run("pp_loop",     1'b1, 1'b1, 64, 60, 1'b0, 1'b1);
        run("rst_mid",     1'b0, 1'b0, 24, 17, 1'b1, 1'b0);

        for (int r = 0; r < 4; r++) begin
            lp = 1'($urandom % 2);
            p  = 1'($urandom % 2);
            ar = 1'($urandom % 2);
            if (lp)                ab = int'($urandom_range(5, 55));
            else if ($urandom % 2) ab = int'($urandom_range(5, 50));
            else                   ab = -1;
            run($sformatf("rand%0d", r), lp, p, 60, ab, ar, 1'b1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
